// File: rtl/multicycle_alu.sv
// multicycle_alu: registered, handshaked ALU with an iterative shift-add
// multiplier. Single-cycle operations complete on the accept edge. MUL
// iterates once per clock for WORD_SIZE cycles. Results and flags are held
// until the consumer takes them.
//
// Handshake semantics, both sides: a transfer happens on a rising edge
// where valid && ready. The producer keeps valid and its payload stable
// until that edge. out_valid drops only after such a transfer, or on reset.
// in_ready may depend combinationally on out_ready. This lets a result
// leave and a new operation enter on the same edge.
module multicycle_alu #(
    parameter int WORD_SIZE = 32,
    localparam int SHAMT_W = $clog2(WORD_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           alu_op,
    input  logic [3:0]           opcode,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] result,
    output logic                 zero,
    output logic                 eq,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WORD_SIZE - 1);

    state_t state, state_nxt;

    logic                 accept;
    logic                 is_mul;
    logic [WORD_SIZE-1:0] op_res;
    logic                 op_ovf;
    logic [WORD_SIZE-1:0] sum, diff;
    logic                 add_ovf, sub_ovf;

    // Multiplier iteration registers
    logic [WORD_SIZE-1:0] mcand, mplr, acc;
    logic [SHAMT_W-1:0]   cnt;
    logic                 mul_eq;
    logic [WORD_SIZE-1:0] acc_nxt;
    logic                 mul_last;

    assign in_ready  = !rst && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);

    assign sum      = a + b;
    assign diff     = a - b;
    assign add_ovf  = (a[WORD_SIZE-1] == b[WORD_SIZE-1]) && (sum[WORD_SIZE-1] != a[WORD_SIZE-1]);
    assign sub_ovf  = (a[WORD_SIZE-1] != b[WORD_SIZE-1]) && (diff[WORD_SIZE-1] != a[WORD_SIZE-1]);
    assign acc_nxt  = mplr[0] ? (acc + mcand) : acc;
    assign mul_last = (state == S_MUL) && (cnt == CNT_LAST);

    // Decode the presented operation into a single-cycle result and overflow flag
    always_comb begin
        op_res = '1;
        op_ovf = 1'b0;
        is_mul = 1'b0;
        case (alu_op)
            2'b00: begin
                op_res = sum;
                op_ovf = add_ovf;
            end
            2'b01: begin
                op_res = diff;
                op_ovf = sub_ovf;
            end
            2'b10: begin
                case (opcode)
                    4'b0000: op_res = a;
                    4'b0010: begin
                        op_res = sum;
                        op_ovf = add_ovf;
                    end
                    4'b0011: begin
                        op_res = diff;
                        op_ovf = sub_ovf;
                    end
                    4'b0100: op_res = a | b;
                    4'b0101: op_res = a & b;
                    4'b0110: op_res = a ^ b;
                    4'b0111: op_res = {{(WORD_SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
                    4'b1000: is_mul = 1'b1;
                    4'b1001: op_res = b;
                    4'b1011: op_res = b;
                    4'b1100: op_res = a;
                    4'b1101: op_res = a << b[SHAMT_W-1:0];
                    4'b1110: op_res = a >> b[SHAMT_W-1:0];
                    default: op_res = '1;
                endcase
            end
            default: begin
                if ((opcode == 4'b1100) || (opcode == 4'b1011)) begin
                    op_res = b;
                end
            end
        endcase
    end

    // Next-state logic for the IDLE / MUL / DONE sequencer
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = is_mul ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (accept) begin
                    state_nxt = is_mul ? S_MUL : S_DONE;
                end else if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output registers: load on a single-cycle accept or on the last MUL iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b0;
            eq     <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept && !is_mul) begin
            result <= op_res;
            zero   <= (op_res == '0);
            eq     <= (a == b);
            ovf    <= op_ovf;
        end else if (mul_last) begin
            result <= acc_nxt;
            zero   <= (acc_nxt == '0);
            eq     <= mul_eq;
            ovf    <= 1'b0;
        end
    end

    // Shift-add multiplier: load at accept, then one partial product per edge
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplr   <= '0;
            acc    <= '0;
            cnt    <= '0;
            mul_eq <= 1'b0;
        end else if (accept && is_mul) begin
            mcand  <= a;
            mplr   <= b;
            acc    <= '0;
            cnt    <= '0;
            mul_eq <= (a == b);
        end else if (state == S_MUL) begin
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Testbench for multicycle_alu. Directed scenarios come first, then random
// traffic with random backpressure and occasional resets. Each result is
// compared with a transaction-level reference model.
module tb_multicycle_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   alu_op;
    logic [3:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         eq;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    // Expected outputs, packed as {result, zero, eq, ovf}
    logic [W+2:0] exp_q[$];
    int           m_busy  = 0;  // edges left until a pending MUL completes
    bit           m_valid = 0;  // model's view of out_valid

    multicycle_alu #(.WORD_SIZE(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .opcode(opcode), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .eq(eq), .ovf(ovf)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Reference ALU computed from the operation definitions with plain arithmetic
    function automatic logic [W+2:0] ref_op(input logic [1:0] op, input logic [3:0] opc,
                                            input logic [W-1:0] x, input logic [W-1:0] y,
                                            output bit mul);
        longint sx, sy, s;
        longint maxs, mins;
        logic [63:0] p;
        logic [W-1:0] r;
        bit v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        maxs = (longint'(1) << (W - 1)) - 1;
        mins = -(longint'(1) << (W - 1));
        mul = 0;
        r = '1;
        v = 0;
        if (op == 2'b00 || (op == 2'b10 && opc == 4'd2)) begin
            s = sx + sy;
            r = x + y;
            v = (s > maxs) || (s < mins);
        end else if (op == 2'b01 || (op == 2'b10 && opc == 4'd3)) begin
            s = sx - sy;
            r = x - y;
            v = (s > maxs) || (s < mins);
        end else if (op == 2'b10) begin
            case (opc)
                4'd0:  r = x;
                4'd4:  r = x | y;
                4'd5:  r = x & y;
                4'd6:  r = x ^ y;
                4'd7:  r = (sx < sy) ? 1 : 0;
                4'd8:  begin
                    p = {32'b0, x} * {32'b0, y};
                    r = p[W-1:0];
                    mul = 1;
                end
                4'd9:  r = y;
                4'd11: r = y;
                4'd12: r = x;
                4'd13: r = x << (y % W);
                4'd14: r = x >> (y % W);
                default: r = '1;
            endcase
        end else begin
            if (opc == 4'd12 || opc == 4'd11) r = y;
        end
        return {r, (r == '0), (x == y), v};
    endfunction

    // Driver: present inputs for one clock, check outputs, advance the model
    task automatic cycle(input bit iv, input logic [1:0] op, input logic [3:0] opc,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit ordy, input bit r);
        bit exp_rdy;
        bit mul;
        logic [W+2:0] e;
        in_valid = iv;
        alu_op = op;
        opcode = opc;
        a = x;
        b = y;
        out_ready = ordy;
        rst = r;
        #1;
        exp_rdy = !r && (m_busy == 0) && (!m_valid || ordy);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, m_valid);
        if (m_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            check("result", result, e[W+2:3]);
            check("zero", zero, e[2]);
            check("eq", eq, e[1]);
            check("ovf", ovf, e[0]);
        end
        if (r) begin
            exp_q.delete();
            m_busy = 0;
            m_valid = 0;
        end else begin
            if (m_valid && ordy) begin
                m_valid = 0;
                void'(exp_q.pop_front());
            end
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_valid = 1;
            end
            if (iv && exp_rdy) begin
                e = ref_op(op, opc, x, y, mul);
                exp_q.push_back(e);
                if (mul) m_busy = W;
                else m_valid = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 2'b00, 4'd0, '0, '0, ordy, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 4'd0, '0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_eq", eq, 0);
        check("rst_ovf", ovf, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return '1;
            5: return W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    // Main sequence
    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        alu_op = 2'b00;
        opcode = 4'd0;
        a = '0;
        b = '0;
        out_ready = 1'b0;
        @(negedge clk);

        do_reset(2);

        // ADD wrap, SUB overflow, SLT
        cycle(1'b1, 2'b00, 4'd0, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
        cycle(1'b1, 2'b01, 4'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        cycle(1'b1, 2'b10, 4'd7, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
        idle(1'b1);

        // MUL with stray in_valid pulses while busy
        cycle(1'b1, 2'b10, 4'd8, 32'h0001_2345, 32'h10, 1'b1, 1'b0);
        for (int i = 0; i < 31; i++)
            cycle(1'($urandom_range(0, 1)), 2'b00, 4'd0, W'($urandom), W'($urandom), 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Backpressure on XOR, then SLL accepted on the releasing edge
        cycle(1'b1, 2'b10, 4'd6, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 2'b10, 4'd0, W'($urandom), W'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 4'd13, 32'h1, 32'd31, 1'b1, 1'b0);
        cycle(1'b1, 2'b10, 4'd15, 32'h1234, 32'h5678, 1'b1, 1'b0);
        cycle(1'b1, 2'b11, 4'd12, 32'h1, 32'hCAFE, 1'b1, 1'b0);
        cycle(1'b1, 2'b11, 4'd11, 32'h2, 32'h2, 1'b1, 1'b0);
        cycle(1'b1, 2'b11, 4'd5, 32'h3, 32'h4, 1'b1, 1'b0);
        idle(1'b1);

        // Reset in the middle of a MUL discards it
        cycle(1'b1, 2'b10, 4'd8, 32'h3, 32'h5, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++)
            cycle(1'($urandom_range(0, 1)), 2'b10, 4'd0, W'($urandom), W'($urandom), 1'b1, 1'b0);
        cycle(1'b1, 2'b10, 4'd8, 32'h7, 32'h9, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) idle(1'b1);

        // Random traffic
        for (int i = 0; i < 700; i++) begin
            logic [1:0] op;
            logic [3:0] opc;
            op = 2'($urandom_range(0, 3));
            opc = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            cycle(1'($urandom_range(0, 1)), op, opc, pick(), pick(),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 40; i++) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Registered, handshaked successor to the team's combinational datapath ALU. Same `alu_op` / `opcode` decode, generalised to `WORD_SIZE`. Adds:
- an iterative shift-add multiply,
- logical shifts,
- signed-overflow and equality flags,
- valid/ready handshakes on both sides.

It sits between the register-file read stage and writeback, so a multi-cycle operation can stall the issuing stage cleanly.

## Interface
- `WORD_SIZE`, 32: operand and result width, ≥ 4, power of two.
- `SHAMT_W`, $clog2(WORD_SIZE): shift-amount width, derived; do not override.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept an operation this cycle.
- `alu_op`  in  2  operation class.
- `opcode`  in  4  operation within class 2'b10 / 2'b11.
- `a`  in  WORD_SIZE  first operand.
- `b`  in  WORD_SIZE  second operand (register, or SE/ZE immediate).
- `out_valid`  out  1  `result` / flags valid.
- `out_ready`  in  1  consumer takes result this cycle.
- `result`  out  WORD_SIZE  registered result.
- `zero`  out  1  registered (result == 0).
- `eq`  out  1  registered (a == b) of the accepted operands, for branch compare.
- `ovf`  out  1  registered signed overflow; ADD/SUB classes only, else 0.

## Operation

**Accept.** An operation is accepted when `in_valid && in_ready`.
- `a`, `b`, `alu_op`, `opcode` are sampled only at accept.
- Inputs at any other time are ignored.

**Decode.** ADD and SUB are modulo 2^WORD_SIZE.
- `alu_op` 00: ADD a+b.
- `alu_op` 01: SUB a−b.
- `alu_op` 10, by `opcode`:
  - 0000 MOV a.
  - 0010 ADD.
  - 0011 SUB.
  - 0100 OR.
  - 0101 AND.
  - 0110 XOR.
  - 0111 SLT: signed a<b, giving 1 or 0, zero-extended.
  - 1000 MUL: low WORD_SIZE bits of a*b, multi-cycle.
  - 1001 LI: b.
  - 1011 LWI: b.
  - 1100 SWI data: a.
  - 1101 SLL: a << b[SHAMT_W-1:0].
  - 1110 SRL: a >> b[SHAMT_W-1:0], logical.
  - any other opcode: all-ones.
- `alu_op` 11: `opcode` 1100 or 1011 gives b; any other opcode gives all-ones.

**Flags.**
- `ovf` is set for ADD when both operands have the same sign and the sum's sign differs.
- `ovf` is set for SUB when the operands' signs differ and the difference's sign differs from a.
- `zero`, `eq`, `ovf` are registered together with `result`.

**FSM states.**
- IDLE:
  - `in_ready`=1.
  - Accepting MUL → MUL.
  - Accepting any other op → DONE, with result registered on the accept edge.
- MUL:
  - `in_ready`=0.
  - Iteration registers: multiplicand, multiplier, accumulator, counter `cnt` of width SHAMT_W.
  - At accept, the block loads mcand=a, mplr=b, acc=0, cnt=0.
  - Each MUL edge does:
    - if mplr[0], acc += mcand;
    - mcand <<= 1;
    - mplr >>= 1;
    - cnt++.
  - On the edge where cnt == WORD_SIZE−1, the block registers the final acc to `result` and goes to DONE.
- DONE:
  - `out_valid`=1.
  - `in_ready` = `out_ready`.
  - On `out_ready` with no new accept → IDLE.
  - On `out_ready` with a simultaneous accept → MUL or DONE per the new op. This gives back-to-back throughput.
  - Without `out_ready`: hold `result` and flags stable, stay in DONE.

**Reset.**
- On any edge with `rst`=1: state → IDLE; `result`, `zero`, `eq`, `ovf` → 0; `out_valid` → 0.
- `in_ready` is 0 while `rst`=1, and 1 on the first cycle after `rst` deasserts.
- Reset during MUL or DONE discards the operation; no `out_valid` is produced for it.

## Timing
- Single-cycle ops:
  - Accept on edge N; `out_valid`=1 from edge N.
  - Latency is 1 cycle.
  - Sustained throughput is 1 op/cycle with `out_ready` held high.
- MUL:
  - Accept on edge N; iterations on edges N+1..N+WORD_SIZE; `out_valid` from edge N+WORD_SIZE.
  - Latency is WORD_SIZE cycles. No early termination on zero operands.
- `out_valid` never deasserts without an `out_ready` handshake, except on reset.
- Outputs are purely registered. `in_ready` is the only combinational output, a function of state, `out_ready` and `rst`.

## Test plan
- **Reset:** hold `rst` 2 cycles, then release → `out_valid`=0, `result`=0, all flags 0, `in_ready`=1.
- **ADD wrap:** `alu_op`=00, a=0xFFFFFFFF, b=1, `out_ready`=1 → one cycle later `result`=0, `zero`=1, `ovf`=0, `eq`=0.
- **SUB overflow and SLT:**
  - SUB with a=0x7FFFFFFF, b=0xFFFFFFFF → `result`=0x80000000, `ovf`=1.
  - Then SLT (10/0111) with a=0xFFFFFFFF, b=1 → `result`=1.
- **MUL with busy input:**
  - Issue 10/1000 with a=0x00012345, b=0x10 → `result`=0x00123450 exactly 32 cycles after accept.
  - `in_ready`=0 throughout; `in_valid` pulses during MUL are not captured.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles after an XOR result → `result` stable and `out_valid` high.
  - Then raise `out_ready` while presenting SLL a=1, b=31 → accepted the same cycle; next `result`=0x80000000.
  - Undefined opcode 10/1111 → 0xFFFFFFFF.
- **Reset mid-MUL:** assert `rst` on cycle 10 of a MUL → no `out_valid` for it; IDLE with `in_ready`=1 after release.
